// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction constants and the IF/ID pipeline record.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    // Instruction fetches are word-granular; the two byte-offset bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and fills IF/ID,
// honouring run-enable, flush/redirect and stall with that priority.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [31:0]                   branch_target_i,
    output logic [31:0]                   imem_addr_o,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_idx_o,
    input  logic [31:0]                   imem_data_i,
    output logic [31:0]                   if_id_pc_o,
    output logic [31:0]                   if_id_instr_o,
    output logic                          if_id_valid_o,
    output logic [CNT_W-1:0]              stall_cnt_o,
    output logic [CNT_W-1:0]              flush_cnt_o
);

    localparam int unsigned IDX_W = $clog2(IMEM_WORDS);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_next_seq;
    if_id_t      if_id_q;
    if_id_t      if_id_d;
    logic        stall_evt;
    logic        flush_evt;

    assign pc_next_seq = pc_q + PC_INCR;

    // Frozen fetch masks both requests, and a flush overrides a same-cycle stall.
    assign flush_evt = start_i && flush_i;
    assign stall_evt = start_i && !flush_i && stall_i;

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        if (!start_i) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (flush_i) begin
            pc_d    = align_word(branch_target_i);
            if_id_d = IF_ID_BUBBLE;
        end else if (stall_i) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end else begin
            pc_d          = pc_next_seq;
            if_id_d.pc    = pc_next_seq;
            if_id_d.instr = imem_data_i;
            if_id_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (stall_evt),
        .count_o (stall_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush_evt),
        .count_o (flush_cnt_o)
    );

    assign imem_addr_o   = pc_q;
    assign imem_idx_o    = pc_q[IDX_W+1:2];
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. It sits directly upstream of ID.
- Holds the PC and drives the instruction-memory address. Latches the fetched word into the IF/ID pipeline register.
- Applies the stall request from the hazard detection unit and the flush/redirect request from the branch logic in ID.
- Keeps saturating stall and flush event counters, so benches read the counts directly instead of reconstructing them from internal nets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction-memory depth in words; sets the index width of imem_idx_o.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  run enable; low = fetch frozen, bubbles issued.
- stall_i  in  1  load-use stall from the hazard unit: hold PC and IF/ID.
- flush_i  in  1  taken branch resolved in ID: redirect PC and squash IF/ID.
- branch_target_i  in  32  redirect address; used when flush_i=1.
- imem_addr_o  out  32  byte address of the current fetch (= PC).
- imem_idx_o  out  $clog2(IMEM_WORDS)  word index = PC[$clog2(IMEM_WORDS)+1:2].
- imem_data_i  in  32  combinational instruction-memory read data for imem_idx_o.
- if_id_pc_o  out  32  PC+4 of the instruction held in IF/ID.
- if_id_instr_o  out  32  instruction held in IF/ID.
- if_id_valid_o  out  1  IF/ID holds a real (non-bubble) instruction.
- stall_cnt_o  out  CNT_W  count of stall cycles.
- flush_cnt_o  out  CNT_W  count of flush cycles.

Behaviour:
- Reset, asynchronous, effective immediately and mid-operation: PC=RESET_PC, if_id_pc_o=0, if_id_instr_o=NOP (32'h0), if_id_valid_o=0, both counters=0.
- imem_addr_o = PC, combinational. The instruction appears in IF/ID one cycle after its address is presented (latency 1).
- Per-edge priority, with rst_i above everything:
  1. start_i=0: PC holds; IF/ID is loaded with a bubble (instr=NOP, pc=0, valid=0); counters hold. stall_i and flush_i are ignored.
  2. flush_i=1: PC <= {branch_target_i[31:2],2'b00}; IF/ID is loaded with a bubble; flush_cnt += 1. Flush wins over a simultaneous stall_i, and stall_cnt does not increment.
  3. stall_i=1: PC holds; IF/ID holds all fields; stall_cnt += 1.
  4. Otherwise: PC <= PC+4; IF/ID <= {pc=PC+4, instr=imem_data_i, valid=1}.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- imem_idx_o wraps naturally for PC beyond IMEM_WORDS*4; no error is raised.
- A misaligned branch target is force-aligned by clearing bits [1:0].
- Counters saturate at all-ones and never wrap.
- Flush and stall persisting across several cycles count once per cycle.
- Deasserting start_i mid-run freezes the PC. When start_i is reasserted, fetch resumes from the held PC with no lost or duplicated instruction.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INSTR = 32'h0
  - PC_INCR = 4
  - the IF/ID record fields (pc, instr, valid) as a packed typedef if_id_t, reused by the ID stage.
- One natural sub-module: sat_counter (width param, inc_i, count_o, async active-high reset), instantiated twice, once per event counter.

Test Plan:
- Reset, then start_i=1 with imem holding words A,B,C at 0,4,8 → PC sequence 0,4,8,12. IF/ID shows (4,A,1), (8,B,1), (12,C,1) one cycle behind the PC.
- stall_i=1 for 2 cycles while PC=8 → PC stays 8 and IF/ID stays (8,B,1) for 2 cycles. stall_cnt=2, then fetch resumes at 8 → 12.
- flush_i=1 with branch_target_i=32'h43 at PC=12 → next PC=32'h40, IF/ID is a bubble (0,NOP,0), flush_cnt=1. The next cycle fetches from 32'h40.
- stall_i=1 and flush_i=1 in the same cycle, target 32'h20 → PC=32'h20, bubble, flush_cnt+1, stall_cnt unchanged.
- start_i=0 for 3 cycles at PC=16 → PC holds 16, three bubbles issued, counters unchanged. On start_i=1, IF/ID receives the instruction at 16.
- rst_i pulsed mid-clock while PC=32'h40 and counters are nonzero → outputs go to reset values before the next edge. Separately, CNT_W=2 with 5 consecutive stalls → stall_cnt saturates at 3.
